// File: rtl/iob_cache_write_buffer_pkg.sv
// Shared constants and types for the cache write-through buffer.
package iob_cache_write_buffer_pkg;

  // Default geometry of the cache front-end and of the write buffer.
  localparam int unsigned IobCacheFeAddrW   = 32;
  localparam int unsigned IobCacheFeDataW   = 32;
  localparam int unsigned IobCacheWtbufDepthW = 2;

  // Channel ownership of the head entry: StBusy means the head is in flight.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } wtbuf_state_e;

endpackage

// File: rtl/iob_cache_wtbuf_mem.sv
// Register file holding the queued write entries: synchronous write, asynchronous read.
module iob_cache_wtbuf_mem #(
  parameter int unsigned DEPTH_W = 2,
  parameter int unsigned ENTRY_W = 64
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [2**DEPTH_W];

  // Storage is intentionally not reset; validity is tracked by the level counter.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iob_cache_write_buffer.sv
// Write-through FIFO between the cache front-end and the write channel; drains in order.
module iob_cache_write_buffer
  import iob_cache_write_buffer_pkg::*;
#(
  parameter int unsigned FE_ADDR_W = IobCacheFeAddrW,
  parameter int unsigned FE_DATA_W = IobCacheFeDataW,
  parameter int unsigned DEPTH_W   = IobCacheWtbufDepthW,
  localparam int unsigned FE_NBYTES   = FE_DATA_W / 8,
  localparam int unsigned FE_NBYTES_W = $clog2(FE_NBYTES),
  localparam int unsigned WADDR_W     = FE_ADDR_W - FE_NBYTES_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_valid_i,
  input  logic [WADDR_W-1:0]   wr_addr_i,
  input  logic [FE_NBYTES-1:0] wr_wstrb_i,
  input  logic [FE_DATA_W-1:0] wr_wdata_i,
  output logic                 wr_ready_o,
  output logic                 valid_o,
  output logic [WADDR_W-1:0]   addr_o,
  output logic [FE_NBYTES-1:0] wstrb_o,
  output logic [FE_DATA_W-1:0] wdata_o,
  input  logic                 ready_i,
  output logic                 empty_o,
  output logic [DEPTH_W:0]     level_o
);

  localparam int unsigned ENTRY_W = WADDR_W + FE_NBYTES + FE_DATA_W;
  localparam int unsigned Depth   = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0]   LevelFull = Depth[DEPTH_W:0];
  localparam logic [DEPTH_W:0]   LevelZero = '0;
  localparam logic [DEPTH_W:0]   LevelOne  = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [DEPTH_W:0]   LevelTwo  = LevelOne + LevelOne;
  localparam logic [DEPTH_W-1:0] PtrOne    = {{(DEPTH_W-1){1'b0}}, 1'b1};

  logic [DEPTH_W-1:0] wptr_q, wptr_d;
  logic [DEPTH_W-1:0] rptr_q, rptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  wtbuf_state_e       state_q, state_d;

  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign full     = (level_q == LevelFull);
  assign push     = wr_valid_i & ~full;
  // The channel's ready in the busy state is its ack for the in-flight head.
  assign pop      = (state_q == StBusy) & ready_i & (level_q != LevelZero);
  assign wr_entry = {wr_addr_i, wr_wstrb_i, wr_wdata_i};

  iob_cache_wtbuf_mem #(
    .DEPTH_W(DEPTH_W),
    .ENTRY_W(ENTRY_W)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (push),
    .waddr_i(wptr_q),
    .wdata_i(wr_entry),
    .raddr_i(rptr_q),
    .rdata_o(rd_entry)
  );

  assign {addr_o, wstrb_o, wdata_o} = rd_entry;
  assign wr_ready_o = ~full;
  assign level_o    = level_q;
  assign empty_o    = (level_q == LevelZero) & (state_q == StIdle);

  // Inflight FSM and output decode; in busy, valid_o announces a follow-on entry.
  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_o = (level_q != LevelZero);
        if (valid_o && ready_i) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        valid_o = (level_q >= LevelTwo);
        if (ready_i && !valid_o) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointer and level next-state; simultaneous push and pop keeps the level.
  always_comb begin
    wptr_d  = push ? wptr_q + PtrOne : wptr_q;
    rptr_d  = pop ? rptr_q + PtrOne : rptr_q;
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LevelOne;
    end else if (!push && pop) begin
      level_d = level_q - LevelOne;
    end
  end

  // Control state; reset discards every entry including the one in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      state_q <= StIdle;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
module tb_iob_cache_write_buffer;

  localparam int unsigned WADDR_W = 30;

  logic               clk = 1'b0;
  logic               reset_i;
  logic               wr_valid_i;
  logic [WADDR_W-1:0] wr_addr_i;
  logic [3:0]         wr_wstrb_i;
  logic [31:0]        wr_wdata_i;
  logic               wr_ready_o;
  logic               valid_o;
  logic [WADDR_W-1:0] addr_o;
  logic [3:0]         wstrb_o;
  logic [31:0]        wdata_o;
  logic               ready_i;
  logic               empty_o;
  logic [2:0]         level_o;

  int checks   = 0;
  int failures = 0;

  iob_cache_write_buffer #(
    .FE_ADDR_W(32),
    .FE_DATA_W(32),
    .DEPTH_W  (2)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .wr_valid_i(wr_valid_i),
    .wr_addr_i (wr_addr_i),
    .wr_wstrb_i(wr_wstrb_i),
    .wr_wdata_i(wr_wdata_i),
    .wr_ready_o(wr_ready_o),
    .valid_o   (valid_o),
    .addr_o    (addr_o),
    .wstrb_o   (wstrb_o),
    .wdata_o   (wdata_o),
    .ready_i   (ready_i),
    .empty_o   (empty_o),
    .level_o   (level_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge: apply inputs, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [WADDR_W-1:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic r);
    wr_valid_i = v;
    wr_addr_i  = a;
    wr_wstrb_i = s;
    wr_wdata_i = d;
    ready_i    = r;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    tick(); tick();
    reset_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (wr_ready_o !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready_o); end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 30'h10, 4'hF, 32'hDEADBEEF, 1'b1);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL single_no_fallthrough got=%b exp=0", valid_o); end
    tick();
    // Issue cycle: channel idle and ready.
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid_o); end
    checks++; if (level_o !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level_o); end
    checks++; if (addr_o !== 30'h10 || wstrb_o !== 4'hF || wdata_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_head got=%h/%h/%h exp=10/f/deadbeef", addr_o, wstrb_o, wdata_o); end
    tick();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b0);
    checks++; if (valid_o !== 1'b0 || empty_o !== 1'b0 || level_o !== 3'd1) begin
      failures++; $display("FAIL single_busy got=v%b e%b l%0d exp=v0 e0 l1", valid_o, empty_o, level_o); end
    tick(); tick();
    // Ack three cycles after issue.
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (level_o !== 3'd1) begin failures++; $display("FAIL single_ack_level got=%0d exp=1", level_o); end
    tick();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (level_o !== 3'd0 || empty_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++; $display("FAIL single_drained got=l%0d e%b v%b exp=l0 e1 v0", level_o, empty_o, valid_o); end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = 32'hA000_0000 + i * 32'h111;
    drive(1'b1, 30'h100, 4'hF, d[0], 1'b1); tick();
    drive(1'b1, 30'h101, 4'hF, d[1], 1'b1); tick();
    drive(1'b1, 30'h102, 4'hF, d[2], 1'b0); tick();
    drive(1'b1, 30'h103, 4'hF, d[3], 1'b0); tick();
    drive(1'b1, 30'h104, 4'hF, d[4], 1'b0);
    checks++; if (wr_ready_o !== 1'b0 || level_o !== 3'd4) begin
      failures++; $display("FAIL fill_full got=r%b l%0d exp=r0 l4", wr_ready_o, level_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
      checks++; if (level_o !== 3'(4 - i)) begin
        failures++; $display("FAIL fill_level%0d got=%0d exp=%0d", i, level_o, 4 - i); end
      checks++; if (wdata_o !== d[i] || addr_o !== 30'(32'h100 + i)) begin
        failures++; $display("FAIL fill_order%0d got=%h/%h exp=%h/%h", i, addr_o, wdata_o, 32'h100 + i, d[i]); end
      checks++; if (valid_o !== (i < 3)) begin
        failures++; $display("FAIL fill_valid%0d got=%b exp=%b", i, valid_o, i < 3); end
      if (i == 1) begin
        checks++; if (wr_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready_rise got=%b exp=1", wr_ready_o); end
      end
      tick();
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (level_o !== 3'd0 || empty_o !== 1'b1) begin
      failures++; $display("FAIL fill_drained got=l%0d e%b exp=l0 e1", level_o, empty_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30'(32'h200 + i), 4'hF, 32'hB000_0000 + i, 1'b0); tick();
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (valid_o !== 1'b1 || wdata_o !== 32'hB000_0000) begin
      failures++; $display("FAIL b2b_issue got=v%b %h exp=v1 b0000000", valid_o, wdata_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
      checks++; if (valid_o !== (i < 2) || wdata_o !== 32'hB000_0000 + i || level_o !== 3'(3 - i)) begin
        failures++; $display("FAIL b2b_ack%0d got=v%b %h l%0d exp=v%b %h l%0d", i + 1, valid_o, wdata_o,
                             level_o, i < 2, 32'hB000_0000 + i, 3 - i); end
      tick();
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty_o); end
    tick();
  endtask

  task automatic test_push_pop();
    drive(1'b1, 30'h300, 4'hF, 32'hC0, 1'b0); tick();
    drive(1'b1, 30'h301, 4'hF, 32'hC1, 1'b0); tick();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1); tick();  // issue
    // Ack and push at level 2.
    drive(1'b1, 30'h302, 4'hF, 32'hC2, 1'b1);
    checks++; if (level_o !== 3'd2 || wdata_o !== 32'hC0) begin
      failures++; $display("FAIL pp_l2_before got=l%0d %h exp=l2 c0", level_o, wdata_o); end
    tick();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (level_o !== 3'd2 || wdata_o !== 32'hC1 || valid_o !== 1'b1) begin
      failures++; $display("FAIL pp_l2_after got=l%0d %h v%b exp=l2 c1 v1", level_o, wdata_o, valid_o); end
    tick();
    // Ack at level 1 with a push: new entry not visible at the ack.
    drive(1'b1, 30'h303, 4'hF, 32'hC3, 1'b1);
    checks++; if (level_o !== 3'd1 || valid_o !== 1'b0 || wdata_o !== 32'hC2) begin
      failures++; $display("FAIL pp_l1_ack got=l%0d v%b %h exp=l1 v0 c2", level_o, valid_o, wdata_o); end
    tick();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (level_o !== 3'd1 || valid_o !== 1'b1 || wdata_o !== 32'hC3 || empty_o !== 1'b0) begin
      failures++; $display("FAIL pp_bubble_issue got=l%0d v%b %h exp=l1 v1 c3", level_o, valid_o, wdata_o); end
    tick();
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1); tick();  // ack
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL pp_empty got=%b exp=1", empty_o); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30'(32'h400 + i), 4'hF, 32'hD0 + i, 1'b0); tick();
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1); tick();  // issue
    reset_i = 1'b1;
    drive(1'b0, '0, 4'h0, 32'h0, 1'b0);
    tick();
    reset_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || level_o !== 3'd0 || empty_o !== 1'b1 || wr_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_mid got=v%b l%0d e%b r%b exp=v0 l0 e1 r1", valid_o, level_o,
                           empty_o, wr_ready_o); end
    tick();
  endtask

  task automatic test_strobes();
    logic [3:0]  s [3];
    logic [31:0] d [3];
    s[0] = 4'h1; s[1] = 4'h6; s[2] = 4'h8;
    d[0] = 32'h0000_0011; d[1] = 32'h0022_3300; d[2] = 32'h4400_0000;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30'(32'h500 + i), s[i], d[i], 1'b0); tick();
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1); tick();  // issue entry 0
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
      checks++; if (wstrb_o !== s[i] || wdata_o !== d[i]) begin
        failures++; $display("FAIL strobe%0d got=%h/%h exp=%h/%h", i, wstrb_o, wdata_o, s[i], d[i]); end
      tick();
    end
    drive(1'b0, '0, 4'h0, 32'h0, 1'b1);
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL strobe_empty got=%b exp=1", empty_o); end
    tick();
  endtask

  initial begin
    reset_i    = 1'b1;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_wstrb_i = '0;
    wr_wdata_i = '0;
    ready_i    = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_push_pop();
    test_reset_mid_drain();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
